// File: rtl/xor_mpm_rw.sv
// XOR-based multi-ported memory: WPORTS write ports and RPORTS read ports, built from 1W1R sync-read banks.
// Optional macro XOR_MPM_FORWARD_EN forwards last cycle's writes to reads (read sees wr_en <= M-1).
module xor_mpm_rw #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 256,
    parameter  int WPORTS = 2,
    parameter  int RPORTS = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           busy,
    input  logic [WPORTS-1:0]              wr_en,
    input  logic [WPORTS-1:0][AW-1:0]      wr_addr,
    input  logic [WPORTS-1:0][WIDTH-1:0]   wr_data,
    output logic [WPORTS-1:0]              wr_drop,
    input  logic [RPORTS-1:0]              rd_en,
    input  logic [RPORTS-1:0][AW-1:0]      rd_addr,
    output logic [RPORTS-1:0][WIDTH-1:0]   rd_data,
    output logic [RPORTS-1:0]              rd_valid
);

    localparam int NCOPY = (WPORTS - 1) + RPORTS;

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   clr_addr;

    logic [WPORTS-1:0]             wr_req, wr_win, drop_nx;
    logic [WPORTS-1:0]             s2_valid;
    logic [WPORTS-1:0][AW-1:0]     s2_addr;
    logic [WPORTS-1:0][WIDTH-1:0]  s2_data;
    logic [WIDTH-1:0]              bank_val   [WPORTS];
    logic [WPORTS-1:0]             byp_hit    [WPORTS];
    logic [WPORTS-1:0]             byp_hit_nx [WPORTS];
    logic [WIDTH-1:0]              byp_val    [WPORTS][WPORTS];
    logic [WIDTH-1:0]              byp_val_nx [WPORTS][WPORTS];

    logic [WIDTH-1:0]  mem   [WPORTS][NCOPY][DEPTH];
    logic [WIDTH-1:0]  rdq   [WPORTS][NCOPY];
    logic [AW-1:0]     raddr [WPORTS][NCOPY];

    logic [RPORTS-1:0] rd_v1;
    logic [WIDTH-1:0]  rd_xor  [RPORTS];
    logic [WIDTH-1:0]  rd_word [RPORTS];

    // Copy of bank b that serves writer w (writer b owns the bank and has no copy).
    function automatic int cidx(input int w, input int b);
        return (w < b) ? w : w - 1;
    endfunction

    assign busy = (state == CLEAR);

    // ---------------- clear FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR)
                clr_addr <= (clr_addr == AW'(DEPTH - 1)) ? '0 : clr_addr + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_addr == AW'(DEPTH - 1)) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = CLEAR;
        endcase
    end

    // ---------------- write arbitration (lowest port index wins) ----------------
    always_comb begin
        wr_req  = wr_en & {WPORTS{~busy}};
        drop_nx = '0;
        for (int w = 1; w < WPORTS; w++)
            for (int v = 0; v < w; v++)
                if (wr_req[w] && wr_req[v] && (wr_addr[v] == wr_addr[w]))
                    drop_nx[w] = 1'b1;
        wr_win = wr_req & ~drop_nx;
    end

    // S2: new bank content = data ^ other banks; an other bank committing this very
    // cycle was read stale in S1, so its value was captured from its S2 instead.
    always_comb begin
        for (int w = 0; w < WPORTS; w++) begin
            bank_val[w] = s2_data[w];
            for (int b = 0; b < WPORTS; b++)
                if (b != w)
                    bank_val[w] = bank_val[w] ^ (byp_hit[w][b] ? byp_val[w][b] : rdq[b][cidx(w, b)]);
        end
    end

    always_comb begin
        for (int w = 0; w < WPORTS; w++) begin
            byp_hit_nx[w] = '0;
            for (int b = 0; b < WPORTS; b++) begin
                byp_val_nx[w][b] = bank_val[b];
                if ((b != w) && s2_valid[b] && (s2_addr[b] == wr_addr[w]))
                    byp_hit_nx[w][b] = 1'b1;
            end
        end
    end

    // ---------------- bank copy read addresses ----------------
    always_comb begin
        for (int w = 0; w < WPORTS; w++) begin
            for (int c = 0; c < NCOPY; c++) begin
                int src;
                if (c < WPORTS - 1) begin
                    src         = (c < w) ? c : c + 1;
                    raddr[w][c] = wr_addr[src];
                end else begin
                    src         = c - (WPORTS - 1);
                    raddr[w][c] = rd_addr[src];
                end
            end
        end
    end

    // NOTE: storage arrays carry no reset; the clear FSM zeroes them after every rst.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WPORTS; w++)
            for (int c = 0; c < NCOPY; c++)
                rdq[w][c] <= mem[w][c][raddr[w][c]];
        if (!rst) begin
            for (int w = 0; w < WPORTS; w++) begin
                if (busy) begin
                    for (int c = 0; c < NCOPY; c++)
                        mem[w][c][clr_addr] <= '0;
                end else if (s2_valid[w]) begin
                    for (int c = 0; c < NCOPY; c++)
                        mem[w][c][s2_addr[w]] <= bank_val[w];
                end
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        for (int r = 0; r < RPORTS; r++) begin
            rd_xor[r] = '0;
            for (int w = 0; w < WPORTS; w++)
                rd_xor[r] = rd_xor[r] ^ rdq[w][(WPORTS - 1) + r];
        end
    end

`ifdef XOR_MPM_FORWARD_EN
    logic [RPORTS-1:0] fwd_hit, fwd_hit_nx;
    logic [WIDTH-1:0]  fwd_val    [RPORTS];
    logic [WIDTH-1:0]  fwd_val_nx [RPORTS];

    // S2 holds last cycle's winners (distinct addresses), which the banks miss this cycle.
    always_comb begin
        for (int r = 0; r < RPORTS; r++) begin
            fwd_hit_nx[r] = 1'b0;
            fwd_val_nx[r] = '0;
            for (int w = 0; w < WPORTS; w++)
                if (s2_valid[w] && (s2_addr[w] == rd_addr[r])) begin
                    fwd_hit_nx[r] = 1'b1;
                    fwd_val_nx[r] = s2_data[w];
                end
        end
    end

    always_ff @(posedge clk) begin
        fwd_hit <= fwd_hit_nx;
        for (int r = 0; r < RPORTS; r++)
            fwd_val[r] <= fwd_val_nx[r];
    end

    always_comb begin
        for (int r = 0; r < RPORTS; r++)
            rd_word[r] = fwd_hit[r] ? fwd_val[r] : rd_xor[r];
    end
`else
    always_comb begin
        for (int r = 0; r < RPORTS; r++)
            rd_word[r] = rd_xor[r];
    end
`endif

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= '0;
            wr_drop  <= '0;
            rd_v1    <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            s2_valid <= wr_win;
            wr_drop  <= drop_nx;
            rd_v1    <= rd_en & {RPORTS{~busy}};
            rd_valid <= rd_v1;
            for (int r = 0; r < RPORTS; r++)
                if (rd_v1[r]) rd_data[r] <= rd_word[r];
        end
    end

    always_ff @(posedge clk) begin
        s2_addr <= wr_addr;
        s2_data <= wr_data;
        for (int w = 0; w < WPORTS; w++) begin
            byp_hit[w] <= byp_hit_nx[w];
            for (int b = 0; b < WPORTS; b++)
                byp_val[w][b] <= byp_val_nx[w][b];
        end
    end

endmodule

// File: tb/tb_xor_mpm_rw.sv
// Self-checking bench for xor_mpm_rw (WIDTH=8, DEPTH=16, WPORTS=2, RPORTS=2): vector table plus
// hand-written multi-cycle sequences; read results are checked against a per-port scoreboard.
module tb_xor_mpm_rw;

    logic            clk = 1'b0;
    logic            rst;
    logic            busy;
    logic [1:0]      wr_en;
    logic [1:0][3:0] wr_addr;
    logic [1:0][7:0] wr_data;
    logic [1:0]      wr_drop;
    logic [1:0]      rd_en;
    logic [1:0][3:0] rd_addr;
    logic [1:0][7:0] rd_data;
    logic [1:0]      rd_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    typedef struct {
        logic       we0;
        logic [3:0] a0;
        logic [7:0] d0;
        logic       we1;
        logic [3:0] a1;
        logic [7:0] d1;
        logic [1:0] exp_drop;
        logic [3:0] ra0;
        logic [7:0] ex0;
        logic [3:0] ra1;
        logic [7:0] ex1;
    } vec_t;

    xor_mpm_rw #(.WIDTH(8), .DEPTH(16), .WPORTS(2), .RPORTS(2)) dut (
        .clk(clk), .rst(rst), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one read cycle and record what each enabled port must return 2 cycles later.
    task automatic issue_read(input logic [1:0] en, input logic [3:0] a0, input logic [7:0] e0,
                              input logic [3:0] a1, input logic [7:0] e1);
        exp_t e;
        rd_en      = en;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        if (en[0]) begin e.data = e0; e.due = cyc + 2; sb0.push_back(e); end
        if (en[1]) begin e.data = e1; e.due = cyc + 2; sb1.push_back(e); end
    endtask

    task automatic idle(input int n);
        wr_en = '0;
        rd_en = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        rst = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check(name, 32'(n), 32'd16);
    endtask

    task automatic pop_check(input int r);
        exp_t e;
        if ((r == 0 && sb0.size() == 0) || (r == 1 && sb1.size() == 0)) begin
            check($sformatf("stray_rd_valid%0d", r), 32'd1, 32'd0);
        end else begin
            e = (r == 0) ? sb0.pop_front() : sb1.pop_front();
            check($sformatf("rd_data%0d", r), 32'(rd_data[r]), 32'(e.data));
            check($sformatf("rd_latency%0d", r), 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rd_valid[0] === 1'b1) pop_check(0);
            if (rd_valid[1] === 1'b1) pop_check(1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [7:0] exp_fwd;

        tbl[0] = '{1'b1, 4'd3,  8'hA5, 1'b1, 4'd9,  8'h3C, 2'b00, 4'd3,  8'hA5, 4'd9,  8'h3C};
        tbl[1] = '{1'b1, 4'd5,  8'h11, 1'b1, 4'd5,  8'h22, 2'b10, 4'd5,  8'h11, 4'd5,  8'h11};
        tbl[2] = '{1'b1, 4'd6,  8'h66, 1'b0, 4'd0,  8'h00, 2'b00, 4'd6,  8'h66, 4'd3,  8'hA5};
        tbl[3] = '{1'b1, 4'd8,  8'hC3, 1'b1, 4'd8,  8'hC3, 2'b10, 4'd8,  8'hC3, 4'd9,  8'h3C};
        tbl[4] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  8'h5E, 2'b00, 4'd5,  8'h5E, 4'd6,  8'h66};
        tbl[5] = '{1'b1, 4'd15, 8'hF0, 1'b1, 4'd0,  8'h0F, 2'b00, 4'd15, 8'hF0, 4'd0,  8'h0F};

        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
        tick();

        // Clear after reset, then every address reads 0 on both ports back-to-back.
        do_reset();
        count_busy("busy_len");
        for (int a = 0; a < 16; a++) begin
            issue_read(2'b11, 4'(a), 8'h00, 4'(15 - a), 8'h00);
            tick();
        end
        idle(4);

        // Table: one write cycle, drop check next cycle, read back two cycles after the write.
        for (int i = 0; i < 6; i++) begin
            wr_en      = {tbl[i].we1, tbl[i].we0};
            wr_addr[0] = tbl[i].a0; wr_data[0] = tbl[i].d0;
            wr_addr[1] = tbl[i].a1; wr_data[1] = tbl[i].d1;
            tick();
            wr_en = '0;
            check($sformatf("wr_drop_vec%0d", i), 32'(wr_drop), 32'(tbl[i].exp_drop));
            tick();
            issue_read(2'b11, tbl[i].ra0, tbl[i].ex0, tbl[i].ra1, tbl[i].ex1);
            tick();
            idle(3);
        end

        // Back-to-back writes to one address from different ports (W1 then W0).
        wr_en = 2'b10; wr_addr[1] = 4'd7; wr_data[1] = 8'h77;
        tick();
        wr_en = 2'b01; wr_addr[0] = 4'd7; wr_data[0] = 8'h88;
        check("wr_drop_b2b_a", 32'(wr_drop), 32'd0);
        tick();
        wr_en = '0;
        check("wr_drop_b2b_b", 32'(wr_drop), 32'd0);
`ifdef XOR_MPM_FORWARD_EN
        exp_fwd = 8'h88;
`else
        exp_fwd = 8'h77;
`endif
        issue_read(2'b01, 4'd7, exp_fwd, 4'd0, 8'h00);
        tick();
        rd_en = '0;
        tick();
        issue_read(2'b10, 4'd0, 8'h00, 4'd7, 8'h88);
        tick();
        idle(4);

        // Same hazard in the other direction (W0 then W1).
        wr_en = 2'b01; wr_addr[0] = 4'd12; wr_data[0] = 8'h12;
        tick();
        wr_en = 2'b10; wr_addr[1] = 4'd12; wr_data[1] = 8'h21;
        tick();
        wr_en = '0;
        tick();
        tick();
        issue_read(2'b11, 4'd12, 8'h21, 4'd12, 8'h21);
        tick();
        idle(4);

        // Read one cycle after a write: visible only with forwarding; two cycles after: always.
        wr_en = 2'b01; wr_addr[0] = 4'd2; wr_data[0] = 8'h5A;
        tick();
        wr_en = '0;
`ifdef XOR_MPM_FORWARD_EN
        exp_fwd = 8'h5A;
`else
        exp_fwd = 8'h00;
`endif
        issue_read(2'b01, 4'd2, exp_fwd, 4'd0, 8'h00);
        tick();
        issue_read(2'b10, 4'd0, 8'h00, 4'd2, 8'h5A);
        tick();
        idle(4);
        check("rd_data_hold", 32'(rd_data[1]), 32'h5A);

        // Reset mid-operation and mid-clear: pending read dropped, writes during clear ignored.
        wr_en = 2'b01; wr_addr[0] = 4'd4; wr_data[0] = 8'hFF;
        tick();
        wr_en = '0;
        tick();
        tick();
        issue_read(2'b01, 4'd4, 8'hFF, 4'd0, 8'h00);
        tick();
        idle(3);
        rd_en = 2'b01; rd_addr[0] = 4'd4;
        tick();
        rd_en = '0;
        do_reset();
        wr_en = 2'b01; wr_addr[0] = 4'd4; wr_data[0] = 8'h33;
        rd_en = 2'b11; rd_addr[0] = 4'd4; rd_addr[1] = 4'd4;
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        wr_en = 2'b11; wr_addr[1] = 4'd9; wr_data[1] = 8'h99;
        count_busy("busy_len_rst2");
        wr_en = '0;
        rd_en = '0;
        tick();
        issue_read(2'b11, 4'd4, 8'h00, 4'd9, 8'h00);
        tick();
        idle(5);

        check("sb0_empty", 32'(sb0.size()), 32'd0);
        check("sb1_empty", 32'(sb1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
